// File: rtl/exhaustive_sweep.sv
// Exhaustive-stimulus engine: walks all 2^N_IN vectors, holds each HOLD cycles, captures a truth table.
// Optional macro SWEEP_POPCOUNT_EN adds the `ones` counter of captured 1 responses.
module exhaustive_sweep #(
  parameter int N_IN = 3,
  parameter int HOLD = 10,
  parameter bit GRAY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      stim,
  input  logic                 dut_out,
  output logic [2**N_IN-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN-1:0]      vec_idx
`ifdef SWEEP_POPCOUNT_EN
  ,
  output logic [N_IN:0]        ones
`endif
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic [N_IN-1:0]      vec_q, vec_d;
  logic [N_IN-1:0]      stim_q, stim_d;
  logic [2**N_IN-1:0]   result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [N_IN:0]        ones_q, ones_d;
  logic                 sample_s;
  logic                 last_s;

  // Sequence position to driven vector (binary or reflected Gray)
  function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] idx);
    if (GRAY) begin
      return idx ^ (idx >> 1);
    end else begin
      return idx;
    end
  endfunction

  // A pending sample is discarded when abort arrives on the same edge
  assign sample_s = (state_q == S_DRIVE) && !abort && (hold_q == HOLD_LAST);
  assign last_s   = (vec_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
        end else begin
          state_d = state_q;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sample_s && last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_d   = hold_q;
    vec_d    = vec_q;
    stim_d   = stim_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ones_d   = ones_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          hold_d   = 8'd0;
          vec_d    = '0;
          stim_d   = map_vec('0);
          result_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          ones_d   = '0;
        end else begin
          hold_d = hold_q;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          hold_d = 8'd0;
          vec_d  = '0;
          stim_d = '0;
          busy_d = 1'b0;
          done_d = 1'b0;
        end else if (sample_s) begin
          result_d[stim_q] = dut_out;
          if (dut_out) begin
            ones_d = ones_q + (N_IN+1)'(1);
          end else begin
            ones_d = ones_q;
          end
          hold_d = 8'd0;
          if (last_s) begin
            vec_d  = '0;
            stim_d = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            vec_d  = vec_q + N_IN'(1);
            stim_d = map_vec(vec_q + N_IN'(1));
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        hold_d   = 8'd0;
        vec_d    = '0;
        stim_d   = '0;
        result_d = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        ones_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q   <= 8'd0;
      vec_q    <= '0;
      stim_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ones_q   <= '0;
    end else begin
      hold_q   <= hold_d;
      vec_q    <= vec_d;
      stim_q   <= stim_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ones_q   <= ones_d;
    end
  end

  assign stim    = stim_q;
  assign result  = result_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vec_idx = vec_q;
`ifdef SWEEP_POPCOUNT_EN
  assign ones    = ones_q;
`else
  logic unused_ones_s;
  assign unused_ones_s = ^ones_q;
`endif

endmodule
